obi_demux_1_to_2: RTL and testbench

Address-decoding 1-to-2 OBI demultiplexer. One OBI master port fans out to two OBI slave ports selected by base/mask windows. It tracks outstanding reads so responses return to the master in order, and adds no cycle latency on the request or response path. It is the complement of the fixed-priority 2-to-1 mux: it sits between a single initiator (core or mux output) and a pair of memories or peripherals.

---
 rtl/obi_demux_1_to_2.sv | 152 +++++++++++++++
 tb/tb_obi_demux_1_to_2.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/obi_demux_1_to_2.sv
// Address-decoding 1-to-2 OBI demultiplexer with in-order read tracking.
// Define OBI_DEMUX_DECERR_EN to route unmapped addresses to an internal error responder.
module obi_demux_1_to_2 #(
  parameter logic [31:0] S0_BASE         = 32'h0000_0000,
  parameter logic [31:0] S0_MASK         = 32'hFFFF_0000,
  parameter logic [31:0] S1_BASE         = 32'h0001_0000,
  parameter logic [31:0] S1_MASK         = 32'hFFFF_0000,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        mst_req_i,
  output logic        mst_gnt_o,
  input  logic [31:0] mst_addr_i,
  input  logic        mst_we_i,
  input  logic [3:0]  mst_be_i,
  input  logic [31:0] mst_wdata_i,
  output logic        mst_rvalid_o,
  output logic [31:0] mst_rdata_o,
  output logic        s0_req_o,
  input  logic        s0_gnt_i,
  output logic [31:0] s0_addr_o,
  output logic        s0_we_o,
  output logic [3:0]  s0_be_o,
  output logic [31:0] s0_wdata_o,
  input  logic        s0_rvalid_i,
  input  logic [31:0] s0_rdata_i,
  output logic        s1_req_o,
  input  logic        s1_gnt_i,
  output logic [31:0] s1_addr_o,
  output logic        s1_we_o,
  output logic [3:0]  s1_be_o,
  output logic [31:0] s1_wdata_o,
  input  logic        s1_rvalid_i,
  input  logic [31:0] s1_rdata_i
);

  localparam logic [3:0] MaxCnt = 4'(MAX_OUTSTANDING);
  localparam logic [1:0] TgtS0  = 2'd0;
  localparam logic [1:0] TgtS1  = 2'd1;
`ifdef OBI_DEMUX_DECERR_EN
  localparam logic [1:0]  TgtInt  = 2'd2;
  localparam logic [31:0] ErrData = 32'hBADC_AB1E;
`endif

  logic [3:0]  rd_cnt_q, rd_cnt_d;
  logic [1:0]  cur_tgt_q, cur_tgt_d;
  logic        int_rvalid_q, int_rvalid_d;
  logic        hit0, hit1;
  logic [1:0]  tgt;
  logic        allowed;
  logic        sel_gnt;
  logic        sel_rvalid;
  logic [31:0] sel_rdata;
  logic        rd_acc;

  assign s0_addr_o  = mst_addr_i;
  assign s0_we_o    = mst_we_i;
  assign s0_be_o    = mst_be_i;
  assign s0_wdata_o = mst_wdata_i;
  assign s1_addr_o  = mst_addr_i;
  assign s1_we_o    = mst_we_i;
  assign s1_be_o    = mst_be_i;
  assign s1_wdata_o = mst_wdata_i;

  always_comb begin
    hit0 = (mst_addr_i & S0_MASK) == S0_BASE;
    hit1 = (mst_addr_i & S1_MASK) == S1_BASE;
    if (hit0) begin
      tgt = TgtS0;
    end else if (hit1) begin
      tgt = TgtS1;
    end else begin
`ifdef OBI_DEMUX_DECERR_EN
      tgt = TgtInt;
`else
      tgt = TgtS1;
`endif
    end
  end

  // Response mux follows the target of the oldest outstanding read.
  always_comb begin
    sel_rvalid = 1'b0;
    sel_rdata  = '0;
    case (cur_tgt_q)
      TgtS0: begin
        sel_rvalid = s0_rvalid_i;
        sel_rdata  = s0_rdata_i;
      end
      TgtS1: begin
        sel_rvalid = s1_rvalid_i;
        sel_rdata  = s1_rdata_i;
      end
`ifdef OBI_DEMUX_DECERR_EN
      TgtInt: begin
        sel_rvalid = int_rvalid_q;
        sel_rdata  = ErrData;
      end
`endif
      default: ;
    endcase
  end

  assign mst_rvalid_o = (rd_cnt_q != 4'd0) && sel_rvalid;
  assign mst_rdata_o  = mst_rvalid_o ? sel_rdata : '0;

  // A full tracker frees a slot in the same cycle a response to the same target retires.
  assign allowed = mst_we_i || (rd_cnt_q == 4'd0) ||
                   ((tgt == cur_tgt_q) && ((rd_cnt_q < MaxCnt) || mst_rvalid_o));

  always_comb begin
    case (tgt)
      TgtS0:   sel_gnt = s0_gnt_i;
      TgtS1:   sel_gnt = s1_gnt_i;
      default: sel_gnt = 1'b1;
    endcase
  end

  assign s0_req_o  = mst_req_i && allowed && (tgt == TgtS0);
  assign s1_req_o  = mst_req_i && allowed && (tgt == TgtS1);
  assign mst_gnt_o = sel_gnt && allowed;
  assign rd_acc    = mst_req_i && mst_gnt_o && !mst_we_i;

  always_comb begin
    rd_cnt_d  = rd_cnt_q;
    cur_tgt_d = rd_acc ? tgt : cur_tgt_q;
    if (rd_acc && !mst_rvalid_o) begin
      rd_cnt_d = rd_cnt_q + 4'd1;
    end else if (!rd_acc && mst_rvalid_o) begin
      rd_cnt_d = rd_cnt_q - 4'd1;
    end
`ifdef OBI_DEMUX_DECERR_EN
    int_rvalid_d = rd_acc && (tgt == TgtInt);
`else
    int_rvalid_d = 1'b0;
`endif
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_cnt_q     <= 4'd0;
      cur_tgt_q    <= TgtS0;
      int_rvalid_q <= 1'b0;
    end else begin
      rd_cnt_q     <= rd_cnt_d;
      cur_tgt_q    <= cur_tgt_d;
      int_rvalid_q <= int_rvalid_d;
    end
  end

endmodule

// File: tb/tb_obi_demux_1_to_2.sv
// Bench for obi_demux_1_to_2: directed scenarios plus a randomized run against a
// queue-based model of outstanding reads.
module tb_obi_demux_1_to_2;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        mst_req_i, mst_gnt_o, mst_we_i, mst_rvalid_o;
  logic [31:0] mst_addr_i, mst_wdata_i, mst_rdata_o;
  logic [3:0]  mst_be_i;
  logic        s0_req_o, s0_gnt_i, s0_we_o, s0_rvalid_i;
  logic [31:0] s0_addr_o, s0_wdata_o, s0_rdata_i;
  logic [3:0]  s0_be_o;
  logic        s1_req_o, s1_gnt_i, s1_we_o, s1_rvalid_i;
  logic [31:0] s1_addr_o, s1_wdata_o, s1_rdata_i;
  logic [3:0]  s1_be_o;

  int n_checks = 0;
  int n_errors = 0;

  obi_demux_1_to_2 dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .mst_req_i(mst_req_i), .mst_gnt_o(mst_gnt_o), .mst_addr_i(mst_addr_i),
    .mst_we_i(mst_we_i), .mst_be_i(mst_be_i), .mst_wdata_i(mst_wdata_i),
    .mst_rvalid_o(mst_rvalid_o), .mst_rdata_o(mst_rdata_o),
    .s0_req_o(s0_req_o), .s0_gnt_i(s0_gnt_i), .s0_addr_o(s0_addr_o), .s0_we_o(s0_we_o),
    .s0_be_o(s0_be_o), .s0_wdata_o(s0_wdata_o), .s0_rvalid_i(s0_rvalid_i),
    .s0_rdata_i(s0_rdata_i),
    .s1_req_o(s1_req_o), .s1_gnt_i(s1_gnt_i), .s1_addr_o(s1_addr_o), .s1_we_o(s1_we_o),
    .s1_be_o(s1_be_o), .s1_wdata_o(s1_wdata_o), .s1_rvalid_i(s1_rvalid_i),
    .s1_rdata_i(s1_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    mst_req_i = 1'b0; mst_we_i = 1'b0; mst_addr_i = '0; mst_be_i = 4'hF; mst_wdata_i = '0;
    s0_gnt_i = 1'b0; s0_rvalid_i = 1'b0; s0_rdata_i = '0;
    s1_gnt_i = 1'b0; s1_rvalid_i = 1'b0; s1_rdata_i = '0;
  endtask

  task automatic do_reset();
    idle();
    rst_i = 1'b1;
    tick();
    tick();
    rst_i = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    rst_i = 1'b1;
    mst_req_i = 1'b1; mst_addr_i = 32'h40; s0_gnt_i = 1'b1;
    s0_rvalid_i = 1'b1; s0_rdata_i = 32'hDEAD_BEEF;
    tick();
    #1;
    n_checks++; if (mst_rvalid_o !== 1'b0) begin n_errors++;
      $display("FAIL reset_rvalid: got %b want 0", mst_rvalid_o); end
    n_checks++; if (mst_rdata_o !== 32'h0) begin n_errors++;
      $display("FAIL reset_rdata: got %h want 0", mst_rdata_o); end
    n_checks++; if (s0_req_o !== 1'b1 || mst_gnt_o !== 1'b1 || s1_req_o !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_reqpath: got s0_req=%b gnt=%b s1_req=%b want 1 1 0",
               s0_req_o, mst_gnt_o, s1_req_o); end
    tick();
    rst_i = 1'b0; mst_req_i = 1'b0;
    #1;
    n_checks++; if (mst_rvalid_o !== 1'b0) begin n_errors++;
      $display("FAIL reset_after_rvalid: got %b want 0", mst_rvalid_o); end
    tick();
    idle();
  endtask

  task automatic test_basic_read();
    do_reset();
    mst_req_i = 1'b1; mst_addr_i = 32'h0000_0040; s0_gnt_i = 1'b1;
    #1;
    n_checks++; if (s0_req_o !== 1'b1 || s1_req_o !== 1'b0 || mst_gnt_o !== 1'b1) begin
      n_errors++;
      $display("FAIL basic_req: got s0=%b s1=%b gnt=%b want 1 0 1", s0_req_o, s1_req_o, mst_gnt_o);
    end
    tick();
    mst_req_i = 1'b0; s0_gnt_i = 1'b0;
    #1;
    n_checks++; if (mst_rvalid_o !== 1'b0) begin n_errors++;
      $display("FAIL basic_early_rvalid: got %b want 0", mst_rvalid_o); end
    tick();
    s0_rvalid_i = 1'b1; s0_rdata_i = 32'h1234_5678;
    #1;
    n_checks++; if (mst_rvalid_o !== 1'b1 || mst_rdata_o !== 32'h1234_5678) begin n_errors++;
      $display("FAIL basic_rsp: got %b/%h want 1/12345678", mst_rvalid_o, mst_rdata_o); end
    tick();
    s0_rdata_i = 32'hFFFF_0000;
    #1;
    n_checks++; if (mst_rvalid_o !== 1'b0 || mst_rdata_o !== 32'h0) begin n_errors++;
      $display("FAIL basic_stray: got %b/%h want 0/0", mst_rvalid_o, mst_rdata_o); end
    tick();
    idle();
  endtask

  task automatic test_target_switch();
    logic granted;
    do_reset();
    mst_req_i = 1'b1; mst_addr_i = 32'h0000_0010; s0_gnt_i = 1'b1;
    #1;
    n_checks++; if (mst_gnt_o !== 1'b1) begin n_errors++;
      $display("FAIL switch_first_gnt: got %b want 1", mst_gnt_o); end
    tick();
    mst_addr_i = 32'h0001_0010; s0_gnt_i = 1'b0; s1_gnt_i = 1'b1;
    for (int i = 1; i < 5; i++) begin
      #1;
      n_checks++; if (s1_req_o !== 1'b0 || mst_gnt_o !== 1'b0) begin n_errors++;
        $display("FAIL switch_hold_%0d: got s1_req=%b gnt=%b want 0 0", i, s1_req_o, mst_gnt_o);
      end
      tick();
    end
    s0_rvalid_i = 1'b1; s0_rdata_i = 32'hA5A5_0001;
    #1;
    n_checks++; if (mst_rvalid_o !== 1'b1 || mst_rdata_o !== 32'hA5A5_0001) begin n_errors++;
      $display("FAIL switch_s0_rsp: got %b/%h want 1/a5a50001", mst_rvalid_o, mst_rdata_o); end
    granted = mst_gnt_o;
    tick();
    s0_rvalid_i = 1'b0;
    if (granted) mst_req_i = 1'b0;
    #1;
    n_checks++; if (!granted && (mst_gnt_o !== 1'b1 || s1_req_o !== 1'b1)) begin n_errors++;
      $display("FAIL switch_release: got gnt=%b s1_req=%b want 1 1", mst_gnt_o, s1_req_o); end
    tick();
    mst_req_i = 1'b0; s1_rvalid_i = 1'b1; s1_rdata_i = 32'h0BAD_F00D;
    #1;
    n_checks++; if (mst_rvalid_o !== 1'b1 || mst_rdata_o !== 32'h0BAD_F00D) begin n_errors++;
      $display("FAIL switch_s1_rsp: got %b/%h want 1/0badf00d", mst_rvalid_o, mst_rdata_o); end
    tick();
    idle();
  endtask

  task automatic test_pipeline_limit();
    logic exp;
    do_reset();
    mst_req_i = 1'b1; mst_addr_i = 32'h0001_0000; s1_gnt_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      exp = (i < 2);
      #1;
      n_checks++; if (mst_gnt_o !== exp || s1_req_o !== exp) begin n_errors++;
        $display("FAIL pipe_gnt_%0d: got gnt=%b req=%b want %b", i, mst_gnt_o, s1_req_o, exp);
      end
      tick();
    end
    s1_rvalid_i = 1'b1; s1_rdata_i = 32'h0000_0001;
    #1;
    n_checks++; if (mst_rvalid_o !== 1'b1 || mst_gnt_o !== 1'b1) begin n_errors++;
      $display("FAIL pipe_release: got rvalid=%b gnt=%b want 1 1", mst_rvalid_o, mst_gnt_o); end
    tick();
    s1_rvalid_i = 1'b0;
    #1;
    n_checks++; if (mst_gnt_o !== 1'b0) begin n_errors++;
      $display("FAIL pipe_refull: got %b want 0", mst_gnt_o); end
    tick();
    mst_req_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      s1_rvalid_i = 1'b1; s1_rdata_i = 32'h100 + 32'(i);
      exp = (i < 2);
      #1;
      n_checks++; if (mst_rvalid_o !== exp) begin n_errors++;
        $display("FAIL pipe_drain_%0d: got %b want %b", i, mst_rvalid_o, exp); end
      tick();
    end
    idle();
  endtask

  task automatic test_write_not_blocked();
    do_reset();
    mst_req_i = 1'b1; mst_addr_i = 32'h0000_0040; s0_gnt_i = 1'b1;
    tick();
    mst_we_i = 1'b1; mst_addr_i = 32'h0001_0000; mst_be_i = 4'b0011;
    mst_wdata_i = 32'hCAFE_0001; s0_gnt_i = 1'b0; s1_gnt_i = 1'b1;
    #1;
    n_checks++; if (s1_req_o !== 1'b1 || mst_gnt_o !== 1'b1 || s0_req_o !== 1'b0) begin
      n_errors++;
      $display("FAIL write_gnt: got s1=%b gnt=%b s0=%b want 1 1 0", s1_req_o, mst_gnt_o, s0_req_o);
    end
    n_checks++; if (s1_be_o !== 4'b0011 || s1_we_o !== 1'b1 || s1_wdata_o !== 32'hCAFE_0001 ||
                    s0_addr_o !== 32'h0001_0000) begin n_errors++;
      $display("FAIL write_fanout: got be=%b we=%b wd=%h a0=%h want 0011 1 cafe0001 00010000",
               s1_be_o, s1_we_o, s1_wdata_o, s0_addr_o); end
    tick();
    mst_req_i = 1'b0; mst_we_i = 1'b0; s1_rvalid_i = 1'b1; s1_rdata_i = 32'h7777_7777;
    #1;
    n_checks++; if (mst_rvalid_o !== 1'b0) begin n_errors++;
      $display("FAIL write_no_rsp: got %b want 0", mst_rvalid_o); end
    tick();
    s1_rvalid_i = 1'b0; s0_rvalid_i = 1'b1; s0_rdata_i = 32'h4444_0040;
    #1;
    n_checks++; if (mst_rvalid_o !== 1'b1 || mst_rdata_o !== 32'h4444_0040) begin n_errors++;
      $display("FAIL write_read_rsp: got %b/%h want 1/44440040", mst_rvalid_o, mst_rdata_o); end
    tick();
    idle();
  endtask

  task automatic test_unmapped();
    do_reset();
    mst_req_i = 1'b1; mst_addr_i = 32'h8000_0000; s0_gnt_i = 1'b1; s1_gnt_i = 1'b1;
    #1;
`ifdef OBI_DEMUX_DECERR_EN
    n_checks++; if (s0_req_o !== 1'b0 || s1_req_o !== 1'b0 || mst_gnt_o !== 1'b1) begin
      n_errors++;
      $display("FAIL unmapped_req: got s0=%b s1=%b gnt=%b want 0 0 1", s0_req_o, s1_req_o, mst_gnt_o);
    end
    tick();
    mst_req_i = 1'b0;
    #1;
    n_checks++; if (mst_rvalid_o !== 1'b1 || mst_rdata_o !== 32'hBADC_AB1E) begin n_errors++;
      $display("FAIL unmapped_rsp: got %b/%h want 1/badcab1e", mst_rvalid_o, mst_rdata_o); end
    tick();
    #1;
    n_checks++; if (mst_rvalid_o !== 1'b0) begin n_errors++;
      $display("FAIL unmapped_rsp_once: got %b want 0", mst_rvalid_o); end
`else
    n_checks++; if (s0_req_o !== 1'b0 || s1_req_o !== 1'b1 || mst_gnt_o !== 1'b1) begin
      n_errors++;
      $display("FAIL unmapped_req: got s0=%b s1=%b gnt=%b want 0 1 1", s0_req_o, s1_req_o, mst_gnt_o);
    end
    tick();
    mst_req_i = 1'b0; s1_rvalid_i = 1'b1; s1_rdata_i = 32'h5151_5151;
    #1;
    n_checks++; if (mst_rvalid_o !== 1'b1 || mst_rdata_o !== 32'h5151_5151) begin n_errors++;
      $display("FAIL unmapped_rsp: got %b/%h want 1/51515151", mst_rvalid_o, mst_rdata_o); end
`endif
    tick();
    idle();
  endtask

  task automatic test_reset_mid_read();
    do_reset();
    mst_req_i = 1'b1; mst_addr_i = 32'h0000_0080; s0_gnt_i = 1'b1;
    tick();
    mst_req_i = 1'b0; rst_i = 1'b1;
    tick();
    rst_i = 1'b0; s0_rvalid_i = 1'b1; s0_rdata_i = 32'h9999_9999;
    for (int i = 0; i < 2; i++) begin
      #1;
      n_checks++; if (mst_rvalid_o !== 1'b0 || mst_rdata_o !== 32'h0) begin n_errors++;
        $display("FAIL rstmid_%0d: got %b/%h want 0/0", i, mst_rvalid_o, mst_rdata_o); end
      tick();
    end
    idle();
  endtask

  // Model: a queue of targets for accepted reads plus per-slave queues of data to return.
  task automatic test_random();
    int          out_q[$];
    logic [31:0] d0_q[$];
    logic [31:0] d1_q[$];
    logic        int_due, nxt_due, exp_rsp, allow, exp_gnt, e0, e1;
    logic [31:0] a, exp_data;
    int          tq;
    do_reset();
    int_due = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      case ($urandom_range(0, 2))
        0:       a = {16'h0000, 16'($urandom)};
        1:       a = {16'h0001, 16'($urandom)};
        default: a = {1'b1, 31'($urandom)};
      endcase
      mst_addr_i = a;
      mst_req_i = ($urandom_range(0, 3) != 0);
      mst_we_i = ($urandom_range(0, 3) == 0);
      mst_be_i = 4'($urandom);
      mst_wdata_i = $urandom;
      s0_gnt_i = ($urandom_range(0, 2) != 0);
      s1_gnt_i = ($urandom_range(0, 2) != 0);
      if (d0_q.size() > 0) begin s0_rvalid_i = 1'($urandom); s0_rdata_i = d0_q[0]; end
      else begin s0_rvalid_i = ($urandom_range(0, 7) == 0); s0_rdata_i = $urandom; end
      if (d1_q.size() > 0) begin s1_rvalid_i = 1'($urandom); s1_rdata_i = d1_q[0]; end
      else begin s1_rvalid_i = ($urandom_range(0, 7) == 0); s1_rdata_i = $urandom; end
      #1;
      if (a[31:16] == 16'h0000) tq = 0;
      else if (a[31:16] == 16'h0001) tq = 1;
`ifdef OBI_DEMUX_DECERR_EN
      else tq = 2;
`else
      else tq = 1;
`endif
      exp_rsp = 1'b0;
      exp_data = 32'h0;
      if (out_q.size() > 0) begin
        exp_rsp = (out_q[0] == 0) ? s0_rvalid_i : (out_q[0] == 1) ? s1_rvalid_i : int_due;
        if (exp_rsp)
          exp_data = (out_q[0] == 0) ? d0_q[0] : (out_q[0] == 1) ? d1_q[0] : 32'hBADC_AB1E;
      end
      allow = mst_we_i || (out_q.size() == 0) ||
              (out_q[0] == tq && (out_q.size() < 2 || exp_rsp));
      exp_gnt = allow && ((tq == 0) ? s0_gnt_i : (tq == 1) ? s1_gnt_i : 1'b1);
      e0 = mst_req_i && allow && (tq == 0);
      e1 = mst_req_i && allow && (tq == 1);
      n_checks++; if (mst_gnt_o !== exp_gnt) begin n_errors++;
        $display("FAIL rnd_gnt c=%0d: got %b want %b", c, mst_gnt_o, exp_gnt); end
      n_checks++; if (s0_req_o !== e0 || s1_req_o !== e1) begin n_errors++;
        $display("FAIL rnd_req c=%0d: got %b%b want %b%b", c, s0_req_o, s1_req_o, e0, e1); end
      n_checks++; if (mst_rvalid_o !== exp_rsp) begin n_errors++;
        $display("FAIL rnd_rvalid c=%0d: got %b want %b", c, mst_rvalid_o, exp_rsp); end
      n_checks++; if (mst_rdata_o !== exp_data) begin n_errors++;
        $display("FAIL rnd_rdata c=%0d: got %h want %h", c, mst_rdata_o, exp_data); end
      n_checks++; if (s0_addr_o !== a || s1_wdata_o !== mst_wdata_i) begin n_errors++;
        $display("FAIL rnd_fanout c=%0d: got %h/%h want %h/%h", c, s0_addr_o, s1_wdata_o, a,
                 mst_wdata_i); end
      if (exp_rsp) begin
        if (out_q[0] == 0) void'(d0_q.pop_front());
        else if (out_q[0] == 1) void'(d1_q.pop_front());
        void'(out_q.pop_front());
      end
      nxt_due = 1'b0;
      if (mst_req_i && exp_gnt && !mst_we_i) begin
        out_q.push_back(tq);
        if (tq == 0) d0_q.push_back($urandom);
        else if (tq == 1) d1_q.push_back($urandom);
        else nxt_due = 1'b1;
      end
      int_due = nxt_due;
      tick();
    end
    idle();
  endtask

  initial begin
    rst_i = 1'b1;
    idle();
    test_reset();
    test_basic_read();
    test_target_switch();
    test_pipeline_limit();
    test_write_not_blocked();
    test_unmapped();
    test_reset_mid_read();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
